// File: rtl/reaction_timer_multi_if.sv
// Button inputs and display/result outputs of the reaction timer.
// The master drives the buttons; the slave (timer) drives everything else.
interface reaction_timer_multi_if #(
  parameter int LED_W = 16
);
  logic             BTNC;
  logic             BTNU;
  logic             BTND;
  logic [LED_W-1:0] LED;
  logic [6:0]       seg;
  logic [3:0]       an;
  logic [15:0]      result_bcd;
  logic [15:0]      best_bcd;
  logic             result_valid;

  modport master (
    output BTNC, BTNU, BTND,
    input  LED, seg, an, result_bcd, best_bcd, result_valid
  );

  modport slave (
    input  BTNC, BTNU, BTND,
    output LED, seg, an, result_bcd, best_bcd, result_valid
  );
endinterface

// File: rtl/reaction_timer_multi.sv
// Reaction timer: random wait, millisecond BCD count, best-time tracking,
// false-start indication and a scanned 4-digit seven-segment display.
module reaction_timer_multi #(
  parameter int LED_W        = 16,
  parameter int TICK_DIV     = 100000,
  parameter int SCAN_DIV     = 100000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int DELAY_BITS   = 11,
  parameter int TIMEOUT_MS   = 9999
) (
  input  logic                   clk,
  input  logic                   reset,
  reaction_timer_multi_if.slave  bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = 14;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [LED_W-1:0] alt_pat();
    logic [LED_W-1:0] p;
    p = '0;
    for (int i = 0; i < LED_W; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  localparam logic [15:0]      TO_BCD = to_bcd(TIMEOUT_MS);
  localparam logic [LED_W-1:0] ALT    = alt_pat();
  localparam logic [6:0]       DASH   = 7'b0111111;

  typedef enum logic [2:0] {
    IDLE, WAIT, GO, DONE, EARLY, TIMEOUT
  } state_t;

  state_t           state_q, state_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [15:0]      res_q, res_d;
  logic [15:0]      best_q, best_d;
  logic             valid_q, valid_d;
  logic             sel_q, sel_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [DW-1:0]    delay_q, delay_d;
  logic [7:0]       early_q, early_d;
  logic [SW-1:0]    scan_q, scan_d;
  logic [1:0]       digit_q, digit_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             btnc_q, btnu_q, btnd_q;

  logic             btnc_ev, btnu_ev, btnd_ev;
  logic             tick;
  logic [15:0]      shown;
  logic [3:0]       nib;

  // Round control: button priority, random wait, BCD count, best time.
  always_comb begin
    btnc_ev = bus.BTNC & ~btnc_q;
    btnu_ev = bus.BTNU & ~btnu_q;
    btnd_ev = bus.BTND & ~btnd_q;
    lfsr_d  = {lfsr_q[14:0],
               lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    tick    = (tick_q == TW'(TICK_DIV - 1));
    tick_d  = tick ? '0 : tick_q + TW'(1);
    state_d = state_q;
    led_d   = led_q;
    res_d   = res_q;
    best_d  = best_q;
    delay_d = delay_q;
    early_d = early_q;
    valid_d = 1'b0;
    sel_d   = sel_q ^ btnd_ev;
    if (btnu_ev) begin
      state_d = IDLE;
      led_d   = '0;
      res_d   = '0;
      if (bus.BTND) best_d = 16'h9999;
    end else if (btnc_ev) begin
      unique case (state_q)
        GO: begin
          state_d = DONE;
          led_d   = '0;
          valid_d = 1'b1;
          if (res_q < best_q) best_d = res_q;
        end
        WAIT: begin
          state_d = EARLY;
          led_d   = ALT;
          early_d = '0;
          tick_d  = '0;
        end
        default: begin
          state_d = WAIT;
          led_d   = '0;
          delay_d = DW'(MIN_DELAY_MS)
                  + DW'(lfsr_q[DELAY_BITS-1:0]);
          tick_d  = '0;
        end
      endcase
    end else if (tick) begin
      unique case (state_q)
        WAIT: begin
          if (delay_q <= DW'(1)) begin
            state_d = GO;
            led_d   = '1;
            res_d   = '0;
            delay_d = '0;
            tick_d  = '0;
          end else begin
            delay_d = delay_q - DW'(1);
          end
        end
        GO: begin
          res_d = bcd_inc(res_q);
          if (res_d == TO_BCD) begin
            state_d = TIMEOUT;
            led_d   = '0;
          end
        end
        EARLY: begin
          if (early_q == 8'd249) begin
            early_d = '0;
            led_d   = ~led_q;
          end else begin
            early_d = early_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Display scan: digit walk and segment pattern for the next cycle.
  always_comb begin
    scan_d  = scan_q + SW'(1);
    digit_d = digit_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d  = '0;
      digit_d = digit_q + 2'd1;
    end
    shown = sel_d ? best_d : res_d;
    unique case (digit_d)
      2'd0: nib = shown[3:0];
      2'd1: nib = shown[7:4];
      2'd2: nib = shown[11:8];
      2'd3: nib = shown[15:12];
    endcase
    an_d  = ~(4'b0001 << digit_d);
    seg_d = (state_d == EARLY) ? DASH : seg7(nib);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    btnc_q <= bus.BTNC;
    btnu_q <= bus.BTNU;
    btnd_q <= bus.BTND;
    if (reset) begin
      state_q <= IDLE;
      led_q   <= '0;
      res_q   <= '0;
      best_q  <= 16'h9999;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      lfsr_q  <= 16'hACE1;
      tick_q  <= '0;
      delay_q <= '0;
      early_q <= '0;
      scan_q  <= '0;
      digit_q <= '0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      res_q   <= res_d;
      best_q  <= best_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      lfsr_q  <= lfsr_d;
      tick_q  <= tick_d;
      delay_q <= delay_d;
      early_q <= early_d;
      scan_q  <= scan_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.LED          = led_q;
  assign bus.seg          = seg_q;
  assign bus.an           = an_q;
  assign bus.result_bcd   = res_q;
  assign bus.best_bcd     = best_q;
  assign bus.result_valid = valid_q;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Bench for reaction_timer_multi: directed rounds plus random button
// traffic, every cycle compared with a millisecond-level reference model.
module tb_reaction_timer_multi;

  localparam int LED_W = 16;
  localparam int TD    = 10;
  localparam int SD    = 4;
  localparam int MIN   = 5;
  localparam int DB    = 3;
  localparam int TO    = 50;

  localparam int M_IDLE = 0, M_WAIT = 1, M_GO = 2;
  localparam int M_DONE = 3, M_EARLY = 4, M_TOUT = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reaction_timer_multi_if #(.LED_W(LED_W)) bus ();

  reaction_timer_multi #(
    .LED_W(LED_W), .TICK_DIV(TD), .SCAN_DIV(SD),
    .MIN_DELAY_MS(MIN), .DELAY_BITS(DB), .TIMEOUT_MS(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  int m_mode, m_t, m_delay, m_res, m_best;
  int m_sel, m_valid, m_scan, m_lfsr;
  bit pc, pu, pd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 16'hFFFF;
  endfunction

  function automatic logic [LED_W-1:0] exp_led();
    logic [LED_W-1:0] alt;
    for (int i = 0; i < LED_W; i++) alt[i] = (i % 2 == 0);
    if (m_mode == M_GO) return '1;
    if (m_mode == M_EARLY)
      return ((m_t / (250 * TD)) % 2 == 1) ? ~alt : alt;
    return '0;
  endfunction

  function automatic int cur_digit();
    return (m_scan / SD) % 4;
  endfunction

  function automatic logic [6:0] exp_seg();
    int v;
    if (m_mode == M_EARLY) return 7'b0111111;
    v = (m_sel != 0) ? m_best : m_res;
    for (int i = 0; i < cur_digit(); i++) v = v / 10;
    return seg_of(v % 10);
  endfunction

  // Reference: what the outputs should be after the coming clock edge.
  task automatic model_step();
    bit ec, eu, ed;
    int lf_now;
    ec = bus.BTNC && !pc;
    eu = bus.BTNU && !pu;
    ed = bus.BTND && !pd;
    pc = bus.BTNC;
    pu = bus.BTNU;
    pd = bus.BTND;
    m_valid = 0;
    if (reset) begin
      m_mode = M_IDLE; m_res = 0; m_best = 9999; m_sel = 0;
      m_t = 0; m_scan = 0; m_lfsr = 16'hACE1;
      return;
    end
    m_scan++;
    lf_now = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    if (ed) m_sel = 1 - m_sel;
    if (eu) begin
      m_mode = M_IDLE;
      m_res  = 0;
      if (bus.BTND) m_best = 9999;
    end else if (ec) begin
      if (m_mode == M_GO) begin
        m_mode  = M_DONE;
        m_valid = 1;
        if (m_res < m_best) m_best = m_res;
      end else if (m_mode == M_WAIT) begin
        m_mode = M_EARLY;
        m_t    = 0;
      end else begin
        m_mode  = M_WAIT;
        m_delay = MIN + (lf_now % (1 << DB));
        m_t     = 0;
      end
    end else begin
      m_t++;
      if (m_mode == M_WAIT && m_t == m_delay * TD) begin
        m_mode = M_GO; m_t = 0; m_res = 0;
      end else if (m_mode == M_GO) begin
        m_res = m_t / TD;
        if (m_res == TO) m_mode = M_TOUT;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("led", 32'(bus.LED), 32'(exp_led()));
    chk("result", 32'(bus.result_bcd), 32'(bcd(m_res)));
    chk("best", 32'(bus.best_bcd), 32'(bcd(m_best)));
    chk("valid", 32'(bus.result_valid), 32'(m_valid));
    chk("an", 32'(bus.an), 32'(4'hF & ~(4'b0001 << cur_digit())));
    chk("seg", 32'(bus.seg), 32'(exp_seg()));
    @(negedge clk);
  endtask

  task automatic wait_mode(input int md, input int lim, input string tag);
    int n;
    n = 0;
    while (m_mode != md && n < lim) begin
      cyc();
      n++;
    end
    chk(tag, 32'(m_mode), 32'(md));
  endtask

  task automatic press_c();
    bus.BTNC = 1'b1;
    cyc();
    bus.BTNC = 1'b0;
    cyc();
  endtask

  initial begin
    m_mode = M_IDLE; m_t = 0; m_delay = 0; m_res = 0; m_best = 9999;
    m_sel = 0; m_valid = 0; m_scan = 0; m_lfsr = 16'hACE1;
    pc = 0; pu = 0; pd = 0;
    reset = 1'b1;
    bus.BTNC = 1'b0;
    bus.BTNU = 1'b0;
    bus.BTND = 1'b0;
    cyc();
    cyc();
    chk("rst_best", 32'(bus.best_bcd), 32'h9999);
    chk("rst_seg", 32'(bus.seg), 32'h40);
    reset = 1'b0;

    // Held start button: one event, then the random wait.
    bus.BTNC = 1'b1;
    cyc();
    cyc();
    bus.BTNC = 1'b0;
    wait_mode(M_GO, 300, "reach_go");
    chk("go_led", 32'(bus.LED), 32'hFFFF);
    for (int i = 0; i < 120; i++) cyc();
    bus.BTNC = 1'b1;
    cyc();
    bus.BTNC = 1'b0;
    chk("done_res", 32'(bus.result_bcd), 32'h0012);
    chk("done_vld", 32'(bus.result_valid), 32'h1);
    chk("done_best", 32'(bus.best_bcd), 32'h0012);
    cyc();
    chk("vld_pulse", 32'(bus.result_valid), 32'h0);

    // False start, then the slow LED toggle.
    press_c();
    cyc();
    bus.BTNC = 1'b1;
    cyc();
    bus.BTNC = 1'b0;
    chk("early_led", 32'(bus.LED), 32'h5555);
    chk("early_seg", 32'(bus.seg), 32'h3F);
    for (int i = 0; i < 2499; i++) cyc();
    chk("early_hold", 32'(bus.LED), 32'h5555);
    cyc();
    chk("early_flip", 32'(bus.LED), 32'hAAAA);
    chk("early_best", 32'(bus.best_bcd), 32'h0012);

    // No stop: timeout.
    press_c();
    wait_mode(M_GO, 300, "reach_go2");
    wait_mode(M_TOUT, 700, "reach_tout");
    chk("tout_res", 32'(bus.result_bcd), 32'h0050);
    chk("tout_led", 32'(bus.LED), 32'h0);
    chk("tout_best", 32'(bus.best_bcd), 32'h0012);

    // Clear variants.
    bus.BTNU = 1'b1;
    cyc();
    bus.BTNU = 1'b0;
    cyc();
    chk("clr_res", 32'(bus.result_bcd), 32'h0);
    chk("clr_best", 32'(bus.best_bcd), 32'h0012);
    bus.BTNU = 1'b1;
    bus.BTND = 1'b1;
    cyc();
    bus.BTNU = 1'b0;
    bus.BTND = 1'b0;
    cyc();
    chk("clr_best2", 32'(bus.best_bcd), 32'h9999);
    press_c();
    bus.BTNU = 1'b1;
    bus.BTNC = 1'b1;
    cyc();
    bus.BTNU = 1'b0;
    bus.BTNC = 1'b0;
    for (int i = 0; i < 200; i++) cyc();
    chk("uc_led", 32'(bus.LED), 32'h0);

    // Reset in the middle of GO, then the anode walk.
    press_c();
    wait_mode(M_GO, 300, "reach_go3");
    for (int i = 0; i < 37; i++) cyc();
    reset = 1'b1;
    bus.BTNC = 1'b1;
    cyc();
    reset = 1'b0;
    bus.BTNC = 1'b0;
    chk("mid_led", 32'(bus.LED), 32'h0);
    chk("mid_res", 32'(bus.result_bcd), 32'h0);
    chk("mid_an", 32'(bus.an), 32'hE);
    for (int i = 1; i < 16; i++) begin
      cyc();
      chk("scan", 32'(bus.an), 32'(4'hF & ~(4'b0001 << ((i / 4) % 4))));
    end

    // Random button traffic.
    for (int i = 0; i < 20000; i++) begin
      bus.BTNC = bus.BTNC ? ($urandom_range(1) == 1)
                          : ($urandom_range(119) == 0);
      bus.BTNU = bus.BTNU ? ($urandom_range(1) == 1)
                          : ($urandom_range(2999) == 0);
      bus.BTND = bus.BTND ? ($urandom_range(1) == 1)
                          : ($urandom_range(199) == 0);
      reset = ($urandom_range(7999) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reaction_timer_multi.md
REACTION_TIMER_MULTI -- requirements
Module: reaction_timer_multi

Interface
REQ-001 Parameter LED_W, 16: width of the LED output, 1..16.
REQ-002 Parameter TICK_DIV, 100000: clk cycles per millisecond tick, >=2.
REQ-003 Parameter SCAN_DIV, 100000: clk cycles each display digit is driven, >=2.
REQ-004 Parameter MIN_DELAY_MS, 1000: minimum random wait before GO, 1..8191.
REQ-005 Parameter DELAY_BITS, 11: number of LFSR bits added to MIN_DELAY_MS, 1..13.
REQ-006 Parameter TIMEOUT_MS, 9999: reaction count that forces TIMEOUT, 1..9999.
REQ-007 clk  input  1  single system clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 BTNC  input  1  start/stop button, debounced and synchronous to clk.
REQ-010 BTNU  input  1  clear button, debounced and synchronous to clk.
REQ-011 BTND  input  1  display-select button: toggles between last and best result.
REQ-012 LED  output  LED_W  reaction LEDs, active-high.
REQ-013 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 an  output  4  digit anodes, active-low; an[0] is the rightmost digit.
REQ-015 result_bcd  output  16  last result, 4 BCD digits, [15:12] most significant.
REQ-016 best_bcd  output  16  best (lowest) valid result since reset or best-clear, BCD.
REQ-017 result_valid  output  1  one-cycle pulse when a new result is captured in DONE.

Function
REQ-018 Button events: each button is edge-detected against its previous-cycle value; an event is a 0->1 transition, so a held button produces one event.
REQ-019 States: IDLE, WAIT, GO, DONE, EARLY, TIMEOUT; state, LED and result registers update on the clock edge after the event cycle.
REQ-020 Priority per cycle: BTNU event > BTNC event > internal timer events.
REQ-021 IDLE: BTNC event -> WAIT; load delay = MIN_DELAY_MS + LFSR[DELAY_BITS-1:0]; restart the tick divider.
REQ-022 LFSR: 16-bit Fibonacci, taps 16,14,13,11; free-runs every cycle; reset seed 16'hACE1; never all-zero.
REQ-023 WAIT: each tick decrements delay; when delay reaches 0 -> GO, result_bcd cleared to 0000, tick divider restarted; LED stays 0.
REQ-024 WAIT + BTNC event -> EARLY, including a BTNC event on the same cycle the delay reaches 0.
REQ-025 GO: LED all ones; result_bcd BCD-increments on every tick, with digit carry 9->0.
REQ-026 GO + BTNC event -> DONE: result_bcd freezes at its current value (a tick on that cycle is not counted); result_valid pulses; LED -> 0.
REQ-027 DONE: if result_bcd < best_bcd, best_bcd <= result_bcd on the same edge.
REQ-028 GO: when result_bcd equals TIMEOUT_MS -> TIMEOUT; LED -> 0; no result_valid; best_bcd unchanged.
REQ-029 EARLY: LED alternates 0101... pattern, LED[0]=1, inverting every 250 ticks; display shows "----" (seg 7'b0111111).
REQ-030 DONE, EARLY or TIMEOUT + BTNC event -> WAIT, starting a new round exactly as REQ-021.
REQ-031 BTNU event, any state -> IDLE, LED 0, result_bcd 0000; best_bcd is kept unless BTND is also high that cycle, in which case best_bcd <= 9999.
REQ-032 BTND event toggles the display select; selecting best does not alter any state.
REQ-033 Display: when not in EARLY, shows the selected value in decimal with no blanking of leading zeros.
REQ-034 Display scan: an walks an[0]..an[3], one digit per SCAN_DIV cycles, with exactly one anode low at a time.

Reset
REQ-035 On reset: state IDLE; LED 0; result_bcd 0000; best_bcd 9999; result_valid 0; display select = last; an 4'b1110; seg 7'b1000000; dividers 0; LFSR 16'hACE1.
REQ-036 Reset asserted in any state, including mid-GO, overrides all button events that cycle.

Verification (TICK_DIV=10, SCAN_DIV=4, MIN_DELAY_MS=5, DELAY_BITS=3, TIMEOUT_MS=50)
REQ-037 Release reset, pulse BTNC 2 cycles -> WAIT; LED goes all ones after exactly (5+LFSR[2:0]) x 10 cycles; a single event is seen.
REQ-038 In GO, pulse BTNC after 12 ticks -> DONE; result_bcd=0012; result_valid 1 cycle; best_bcd=0012; LED=0.
REQ-039 Press BTNC again, then press BTNC during WAIT -> EARLY; display "----"; LED=16'h5555 toggling every 2500 cycles; best_bcd stays 0012.
REQ-040 Start a round and give no stop -> TIMEOUT at result_bcd=0050; LED=0; no result_valid pulse.
REQ-041 BTNU alone -> IDLE with result 0000 and best 0012; then BTNU+BTND together -> best 9999; BTNU+BTNC in the same cycle -> IDLE.
REQ-042 Assert reset mid-GO -> all REQ-035 values on the next edge; scan an sequence 1110,1101,1011,0111 with a 4-cycle period each.
